// File: rtl/wb_lite_master.sv
// Wishbone classic initiator: turns valid/ready commands into single or fixed-length
// incrementing bus transfers and returns one response (data + status) per beat.
module wb_lite_master #(
  parameter int TIMEOUT = 255,
  parameter int LEN_W   = 4,
  parameter int ADR_INC = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [31:0]      cmd_dat,
  input  logic [3:0]       cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_dat,
  output logic             rsp_err,
  output logic             rsp_timeout,
  output logic             rsp_last,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] ADR_STEP   = 32'(ADR_INC);

  state_t           state, state_nx;
  logic [LEN_W-1:0] beats, beats_nx;
  logic [15:0]      timer, timer_nx;

  logic             cmd_ready_nx;
  logic             cyc_nx, stb_nx, we_nx;
  logic [3:0]       sel_nx;
  logic [31:0]      adr_nx, dat_nx;
  logic             rsp_valid_nx, rsp_err_nx, rsp_timeout_nx, rsp_last_nx;
  logic [31:0]      rsp_dat_nx;

  logic             cmd_fire, rsp_fire;
  logic             bus_ack, bus_err, bus_to, bus_done;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // err beats ack; a real ack/err on the final timer edge beats the timeout
  assign bus_err  = wbm_cyc_o && wbm_err_i;
  assign bus_ack  = wbm_cyc_o && wbm_ack_i && !wbm_err_i;
  assign bus_to   = wbm_cyc_o && !wbm_ack_i && !wbm_err_i && (timer == TIMER_LAST);
  assign bus_done = bus_ack || bus_err || bus_to;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      beats       <= '0;
      timer       <= '0;
      cmd_ready   <= 1'b1;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid   <= 1'b0;
      rsp_dat     <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_last    <= 1'b0;
    end else begin
      state       <= state_nx;
      beats       <= beats_nx;
      timer       <= timer_nx;
      cmd_ready   <= cmd_ready_nx;
      wbm_cyc_o   <= cyc_nx;
      wbm_stb_o   <= stb_nx;
      wbm_we_o    <= we_nx;
      wbm_sel_o   <= sel_nx;
      wbm_adr_o   <= adr_nx;
      wbm_dat_o   <= dat_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_dat     <= rsp_dat_nx;
      rsp_err     <= rsp_err_nx;
      rsp_timeout <= rsp_timeout_nx;
      rsp_last    <= rsp_last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cmd_fire) state_nx = BUS;
      BUS:     if (bus_done) state_nx = RESP;
      RESP:    if (rsp_fire) state_nx = rsp_last ? IDLE : BUS;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for every registered output; anything not touched holds its value
  always_comb begin
    beats_nx       = beats;
    timer_nx       = timer;
    cmd_ready_nx   = cmd_ready;
    cyc_nx         = wbm_cyc_o;
    stb_nx         = wbm_stb_o;
    we_nx          = wbm_we_o;
    sel_nx         = wbm_sel_o;
    adr_nx         = wbm_adr_o;
    dat_nx         = wbm_dat_o;
    rsp_valid_nx   = rsp_valid;
    rsp_dat_nx     = rsp_dat;
    rsp_err_nx     = rsp_err;
    rsp_timeout_nx = rsp_timeout;
    rsp_last_nx    = rsp_last;
    unique case (state)
      IDLE: begin
        if (cmd_fire) begin
          cmd_ready_nx = 1'b0;
          cyc_nx       = 1'b1;
          stb_nx       = 1'b1;
          we_nx        = cmd_we;
          sel_nx       = cmd_sel;
          adr_nx       = cmd_adr;
          dat_nx       = cmd_dat;
          beats_nx     = cmd_len;
          timer_nx     = '0;
        end
      end
      BUS: begin
        if (bus_done) begin
          cyc_nx         = 1'b0;
          stb_nx         = 1'b0;
          rsp_valid_nx   = 1'b1;
          rsp_dat_nx     = (bus_ack && !wbm_we_o) ? wbm_dat_i : 32'h0;
          rsp_err_nx     = bus_err;
          rsp_timeout_nx = bus_to;
          rsp_last_nx    = (beats == '0) || bus_err || bus_to;
        end else begin
          timer_nx = timer + 16'd1;
        end
      end
      RESP: begin
        if (rsp_fire) begin
          rsp_valid_nx   = 1'b0;
          rsp_dat_nx     = '0;
          rsp_err_nx     = 1'b0;
          rsp_timeout_nx = 1'b0;
          rsp_last_nx    = 1'b0;
          if (rsp_last) begin
            cmd_ready_nx = 1'b1;
          end else begin
            cyc_nx   = 1'b1;
            stb_nx   = 1'b1;
            adr_nx   = wbm_adr_o + ADR_STEP;
            beats_nx = beats - LEN_W'(1);
            timer_nx = '0;
          end
        end
      end
      default: begin
        cmd_ready_nx = 1'b1;
        cyc_nx       = 1'b0;
        stb_nx       = 1'b0;
        rsp_valid_nx = 1'b0;
      end
    endcase
  end

endmodule
